if_fetch: RTL
=============

# if_fetch

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the decode stage. Holds the PC, issues in-order requests to instruction memory, buffers returned words in a small FIFO and presents one instruction plus its PC+4 per cycle to decode over a valid/ready handshake. Accepts redirects (taken branch/jump target) from decode and discards stale in-flight fetches.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 2, FIFO entries and maximum outstanding-plus-buffered fetches (≥2)
- `clk` in 1 clock
- `rst` in 1 asynchronous, active-high reset
- `imem_req` out 1 fetch request valid
- `imem_addr` out 32 fetch address (word aligned, bits 1:0 = 0)
- `imem_gnt` in 1 request accepted this cycle when `imem_req & imem_gnt`
- `imem_rvalid` in 1 read data valid; responses in request order, ≥1 cycle after grant
- `imem_rdata` in 32 instruction word
- `redirect_valid` in 1 decode resolved a taken branch/jump
- `redirect_addr` in 32 target address from decode
- `if_valid` out 1 instruction available to decode
- `if_ready` in 1 decode accepts (low = stall)
- `if_inst` out 32 instruction word
- `if_inst_addr` out 32 PC+4 of `if_inst` (decode forms jump/branch targets from it)

## Operation
- State: `pc`, FIFO (`DEPTH` × {inst, pc+4}), `outstanding` count, `drop` count, `pending_redirect` + address.
- Issue: `imem_req` high when `occupancy + outstanding − pop < DEPTH` and not in reset; `imem_addr = pc`; on grant `pc ← pc + 4`, `outstanding++`.
- Response: on `imem_rvalid`, `outstanding--`; if `drop > 0`, `drop--` and word discarded; else push {rdata, addr+4} (address tracked per request in a `DEPTH`-entry address queue).
- Pop: `if_valid & if_ready` removes head. Outputs are FIFO head; `if_valid` = FIFO non-empty.
- Redirect (no delay slot): FIFO flushed, `drop ← outstanding` (minus any response in the same cycle, which is itself dropped), `pc ← redirect_addr`. A grant in the redirect cycle is also counted into `drop`. Redirect overrides `if_ready` and a simultaneous push.
- Address arithmetic: 32-bit modulo; `pc` wraps 32'hFFFF_FFFC → 0 without error. `redirect_addr[1:0]` ignored (forced 0).
- Full: no request while credit exhausted; responses never overflow FIFO by construction.
- Empty: `if_valid` low; outputs hold last value (not X).

## Timing
- Reset (async assert, sync release): `pc = RESET_PC`, FIFO empty, counts 0, `imem_req = 0`, `if_valid = 0`, `if_inst = 0`, `if_inst_addr = 0`, `imem_addr = RESET_PC`.
- First `imem_req` in first cycle after `rst` deasserts.
- Latency: grant cycle N, `rvalid` cycle N+k → `if_valid` cycle N+k+1 (registered push, no bypass).
- With `gnt` always 1, k=1, `if_ready` 1, `DEPTH`=2: one instruction per cycle sustained.
- Redirect in cycle R: first request to target in R+1; first target instruction earliest `if_valid` at R+3.
- `rst` mid-operation: all state cleared immediately; late responses from before reset are the memory's responsibility (memory reset together).

## Configuration
- `BRANCH_DELAY_SLOT_EN` defined: on redirect exactly one instruction younger than the branch is kept — FIFO head if present; else the next non-dropped response; if none in flight, `pc` (delay-slot address) is fetched first, with `pending_redirect` holding the target until that request is granted. Remaining FIFO entries/outstanding dropped.
- Undefined: redirect flushes all younger instructions as described above; `pending_redirect` logic absent.

## Structure
- Shared package/macros header: `InstAddrBus`, `InstBus` widths, `RESET_PC` default, word-increment constant 4.
- One sub-module `if_fifo` (parameterised `DEPTH`, width 64, push/pop/flush, count output); address queue reuses it at width 32.

## Test plan
- Reset release, `gnt`=1, k=1, `if_ready`=1 → `imem_addr` 0,4,8,…; `if_inst_addr` 4,8,12,… one per cycle from cycle 3.
- `if_ready` low 5 cycles → FIFO fills to 2, `imem_req` drops, `if_inst` stable; release → no loss/duplication.
- Redirect to 32'h0000_0100 with 2 outstanding, k=3 → both late responses dropped, next `if_inst_addr` = 32'h104.
- Redirect coincident with `rvalid` and `if_ready`=0 → redirect wins, response dropped, FIFO empty next cycle.
- `pc` at 32'hFFFF_FFFC → next `imem_addr` 0, `if_inst_addr` of that word = 0.
- `BRANCH_DELAY_SLOT_EN`, branch at 0x8 redirects to 0x40, FIFO empty, nothing outstanding → fetch 0xC then 0x40; decode sees addr+4 = 0x10 then 0x44.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared widths, reset default and FIFO payload type for the instruction-fetch stage.
//   InstAddrBus / InstBus : address and instruction word widths
//   RESET_PC_DEFAULT      : default first fetch address after reset
//   WORD_INC              : byte increment between consecutive instruction words
//   fetch_entry_t         : FIFO payload {instruction, address of instruction + 4}
package if_fetch_pkg;

    localparam int unsigned InstAddrBus = 32;
    localparam int unsigned InstBus     = 32;

    localparam logic [InstAddrBus-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [InstAddrBus-1:0] WORD_INC         = 32'd4;

    typedef struct packed {
        logic [InstBus-1:0]     inst;
        logic [InstAddrBus-1:0] pc4;
    } fetch_entry_t;

    localparam int unsigned EntryW = $bits(fetch_entry_t);

endpackage

// File: rtl/if_fetch_if.sv
// Bundle of the fetch stage's instruction-memory, redirect and decode-side signals.
//   master : fetch stage (drives imem_req/imem_addr and the decode-facing if_* outputs)
//   slave  : environment (instruction memory + decode stage)
interface if_fetch_if;
    import if_fetch_pkg::*;

    logic                   imem_req;
    logic [InstAddrBus-1:0] imem_addr;
    logic                   imem_gnt;
    logic                   imem_rvalid;
    logic [InstBus-1:0]     imem_rdata;
    logic                   redirect_valid;
    logic [InstAddrBus-1:0] redirect_addr;
    logic                   if_valid;
    logic                   if_ready;
    logic [InstBus-1:0]     if_inst;
    logic [InstAddrBus-1:0] if_inst_addr;

    modport master (
        output imem_req, imem_addr, if_valid, if_inst, if_inst_addr,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_addr, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_inst, if_inst_addr,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_addr, if_ready
    );

endinterface

// File: rtl/if_fetch_fifo.sv
// if_fifo: small shift-register FIFO with the head always in slot 0.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   push, din      : write an entry at the tail (ignored when full)
//   pop            : remove the head (ignored when empty)
//   flush          : drop all entries (wins over push/pop)
//   trim           : keep only the head entry (wins over push/pop)
//   dout           : head entry; keeps its last value once the FIFO empties
//   count          : number of valid entries
module if_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    input  logic             flush,
    input  logic             trim,
    output logic [WIDTH-1:0] dout,
    output logic [CntW-1:0]  count
);

    logic [WIDTH-1:0] mem   [DEPTH];
    logic [WIDTH-1:0] mem_n [DEPTH];
    logic             pop_eff;
    logic             push_eff;
    logic [CntW-1:0]  wr_idx;

    assign pop_eff  = pop && (count != '0);
    assign wr_idx   = count - CntW'(pop_eff);
    assign push_eff = push && (32'(wr_idx) < DEPTH);
    assign dout     = mem[0];

    // Slots are only rewritten with valid data, so slot 0 holds the last head when empty.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_n[i] = mem[i];
        end
        if (pop_eff) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                if (i + 1 < 32'(count)) begin
                    mem_n[i] = mem[i + 1];
                end
            end
        end
        if (push_eff) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (32'(wr_idx) == i) begin
                    mem_n[i] = din;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            count <= '0;
        end else if (trim) begin
            count <= (count != '0) ? CntW'(1) : '0;
        end else begin
            count <= wr_idx + CntW'(push_eff);
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= mem_n[i];
            end
        end
    end

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage. Issues in-order word fetches from pc, buffers
// returned words with their address+4, and hands them to decode over valid/ready.
// A redirect from decode flushes younger instructions and drops stale in-flight fetches.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : if_fetch_if.master -- imem_req/addr/gnt/rvalid/rdata,
//              redirect_valid/addr, if_valid/ready/inst/inst_addr
// Parameters: RESET_PC (first fetch address), DEPTH (buffer entries and fetch credit, >=2)
// Build option: BRANCH_DELAY_SLOT_EN -- a redirect keeps exactly one younger instruction
// (the delay slot) instead of flushing all of them.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned            DEPTH    = 2
) (
    input logic       clk,
    input logic       rst,
    if_fetch_if.master bus
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [InstAddrBus-1:0] pc, pc_n;
    logic [CntW-1:0]        drop, drop_n;
    logic [CntW-1:0]        occ;
    logic [CntW-1:0]        outst;
    logic                   fire;
    logic                   pop_raw;
    logic                   pop;
    logic                   push;
    logic                   resp_live;
    logic                   flush;
    logic                   trim;
    logic [InstAddrBus-1:0] redir_tgt;
    logic [InstAddrBus-1:0] aq_head;
    fetch_entry_t           push_entry;
    fetch_entry_t           head_entry;
    logic [EntryW-1:0]      head_raw;

    assign redir_tgt = bus.redirect_addr & ~32'd3;
    assign fire      = bus.imem_req & bus.imem_gnt;
    assign resp_live = bus.imem_rvalid && (drop == '0);
    assign pop_raw   = bus.if_valid & bus.if_ready;
    assign pop       = pop_raw & ~bus.redirect_valid;

    // Credit: buffered + in flight must stay below DEPTH once this cycle's pop leaves.
    assign bus.imem_req  = !rst && ((32'(occ) + 32'(outst)) < (DEPTH + 32'(pop_raw)));
    assign bus.imem_addr = pc;

    assign head_entry       = fetch_entry_t'(head_raw);
    assign bus.if_valid     = (occ != '0);
    assign bus.if_inst      = head_entry.inst;
    assign bus.if_inst_addr = head_entry.pc4;

    assign push_entry = '{inst: bus.imem_rdata, pc4: aq_head + WORD_INC};

    // Instruction buffer: {inst, pc+4} per entry.
    if_fifo #(.DEPTH(DEPTH), .WIDTH(EntryW)) u_inst_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (EntryW'(push_entry)),
        .pop   (pop),
        .flush (flush),
        .trim  (trim),
        .dout  (head_raw),
        .count (occ)
    );

    // Address of every granted request, retired in order by responses (dropped or not).
    if_fifo #(.DEPTH(DEPTH), .WIDTH(InstAddrBus)) u_addr_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fire),
        .din   (pc),
        .pop   (bus.imem_rvalid),
        .flush (1'b0),
        .trim  (1'b0),
        .dout  (aq_head),
        .count (outst)
    );

`ifdef BRANCH_DELAY_SLOT_EN
    logic                   pend, pend_n;
    logic [InstAddrBus-1:0] pend_addr, pend_addr_n;
    logic [CntW-1:0]        tail, tail_n;
    logic [CntW-1:0]        drop_left;
    logic [CntW-1:0]        live_left;

    // Next pc / drop bookkeeping; the delay slot is the buffered head, else the next
    // live response, else a fresh fetch of pc with the target parked in pend_addr.
    always_comb begin
        pc_n        = pc;
        drop_n      = drop;
        tail_n      = tail;
        pend_n      = pend;
        pend_addr_n = pend_addr;
        push        = resp_live;
        flush       = 1'b0;
        trim        = 1'b0;
        drop_left   = drop - CntW'(bus.imem_rvalid && (drop != '0));
        live_left   = outst + CntW'(fire) - CntW'(bus.imem_rvalid) - drop_left;

        if (bus.imem_rvalid && (drop != '0)) begin
            drop_n = drop_left;
        end
        // Kept delay slot has arrived: everything queued behind it is stale.
        if (resp_live && (tail != '0)) begin
            drop_n = tail;
            tail_n = '0;
        end
        if (fire) begin
            pc_n   = pend ? pend_addr : pc + WORD_INC;
            pend_n = 1'b0;
        end

        if (bus.redirect_valid) begin
            tail_n = '0;
            pend_n = 1'b0;
            if (occ != '0) begin
                trim   = 1'b1;
                push   = 1'b0;
                drop_n = outst + CntW'(fire) - CntW'(bus.imem_rvalid);
                pc_n   = redir_tgt;
            end else if (resp_live) begin
                drop_n = outst + CntW'(fire) - CntW'(bus.imem_rvalid);
                pc_n   = redir_tgt;
            end else if (live_left != '0) begin
                drop_n = drop_left;
                tail_n = live_left - CntW'(1);
                pc_n   = redir_tgt;
            end else begin
                pend_n      = 1'b1;
                pend_addr_n = redir_tgt;
                drop_n      = drop_left;
                pc_n        = pc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend      <= 1'b0;
            pend_addr <= '0;
            tail      <= '0;
        end else begin
            pend      <= pend_n;
            pend_addr <= pend_addr_n;
            tail      <= tail_n;
        end
    end
`else
    // Next pc / drop bookkeeping; a redirect discards every younger instruction.
    always_comb begin
        pc_n   = pc;
        drop_n = drop;
        push   = resp_live;
        flush  = 1'b0;
        trim   = 1'b0;

        if (bus.imem_rvalid && (drop != '0)) begin
            drop_n = drop - CntW'(1);
        end
        if (fire) begin
            pc_n = pc + WORD_INC;
        end

        if (bus.redirect_valid) begin
            flush  = 1'b1;
            push   = 1'b0;
            drop_n = outst + CntW'(fire) - CntW'(bus.imem_rvalid);
            pc_n   = redir_tgt;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc   <= RESET_PC;
            drop <= '0;
        end else begin
            pc   <= pc_n;
            drop <= drop_n;
        end
    end

endmodule
